// File: rtl/counter_mod_updown_if.sv
// Control and status bundle for counter_mod_updown.
// The bench or upstream logic drives through master; the counter sits on slave.
interface counter_mod_updown_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             wrap;
   logic             ovf;

   modport master (
      output en, up, clr, load, d,
      input  out, tc, wrap, ovf
   );

   modport slave (
      input  en, up, clr, load, d,
      output out, tc, wrap, ovf
   );
endinterface

// File: rtl/counter_mod_updown.sv
// Modulo-N up/down counter with enable, clear, clamped load, and wrap-or-saturate.
// Also provides a registered wrap pulse, a sticky overflow flag and a cascadable terminal count.
module counter_mod_updown #(
   parameter int unsigned      WIDTH    = 4,
   parameter longint unsigned  MODULUS  = 16,
   parameter bit               SATURATE = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   counter_mod_updown_if.slave  bus
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("counter_mod_updown: WIDTH must be 1..32");
   end
   if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("counter_mod_updown: MODULUS must be 2..2**WIDTH");
   end

   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   ONE   = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   inc, dec;
   logic             at_term;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   always_comb begin
      inc     = {1'b0, out_q} + ONE;
      dec     = {1'b0, out_q} - ONE;
      // Extra bit keeps MODULUS == 2**WIDTH exact; counting down, a borrow flags zero.
      at_term = bus.up ? (inc == MOD_W) : dec[WIDTH];
   end

   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      if (bus.clr) begin
         out_d = '0;
         ovf_d = 1'b0;
      end else if (bus.load) begin
         out_d = ({1'b0, bus.d} >= MOD_W) ? MAX_V : bus.d;
      end else if (bus.en) begin
         if (!at_term) begin
            out_d = bus.up ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
         end else begin
            ovf_d = 1'b1;
            if (!SATURATE) begin
               out_d  = bus.up ? '0 : MAX_V;
               wrap_d = 1'b1;
            end
         end
      end
   end

   assign bus.out  = out_q;
   assign bus.wrap = wrap_q;
   assign bus.ovf  = ovf_q;
   assign bus.tc   = bus.en & at_term;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Scoreboard bench: four counters (mod-10 wrap, mod-10 saturate, mod-16 cascade pair)
// share one stimulus stream; a modulo-arithmetic model predicts each cycle's outputs.
module tb_counter_mod_updown;
   localparam int unsigned W  = 4;
   localparam int          NI = 4;
   localparam int unsigned MODS [NI] = '{10, 10, 16, 16};
   localparam bit          SATS [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};

   typedef struct packed {
      logic [NI-1:0][W-1:0] out;
      logic [NI-1:0]        wrap;
      logic [NI-1:0]        ovf;
      logic [NI-1:0]        tc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
   logic [W-1:0] d = '0;

   logic [W-1:0] a_out  [NI];
   logic         a_wrap [NI];
   logic         a_ovf  [NI];
   logic         a_tc   [NI];

   int unsigned  m_out  [NI];
   bit           m_wrap [NI];
   bit           m_ovf  [NI];

   exp_t sb [$];
   int   checks = 0, errors = 0, pushed = 0, popped = 0;

   always #5 clk = ~clk;

   counter_mod_updown_if #(.WIDTH(W)) bus [NI] ();

   for (genvar i = 0; i < NI; i++) begin : g_conn
      if (i == 3) begin : g_casc
         assign bus[i].en = bus[2].tc;
      end else begin : g_plain
         assign bus[i].en = en;
      end
      assign bus[i].up   = up;
      assign bus[i].clr  = clr;
      assign bus[i].load = load;
      assign bus[i].d    = d;
      assign a_out[i]    = bus[i].out;
      assign a_wrap[i]   = bus[i].wrap;
      assign a_ovf[i]    = bus[i].ovf;
      assign a_tc[i]     = bus[i].tc;
   end

   counter_mod_updown #(.WIDTH(W), .MODULUS(10), .SATURATE(1'b0)) u_m10 (
      .clk(clk), .rst(rst), .bus(bus[0]));
   counter_mod_updown #(.WIDTH(W), .MODULUS(10), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .bus(bus[1]));
   counter_mod_updown #(.WIDTH(W), .MODULUS(16), .SATURATE(1'b0)) u_lo (
      .clk(clk), .rst(rst), .bus(bus[2]));
   counter_mod_updown #(.WIDTH(W), .MODULUS(16), .SATURATE(1'b0)) u_hi (
      .clk(clk), .rst(rst), .bus(bus[3]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // One clock edge of the reference: counts live in 0..M-1, steps are taken mod M.
   function automatic void advance(input int i, input bit e, input bit u, input bit c,
                                   input bit l, input logic [W-1:0] dv);
      int unsigned m;
      int unsigned nxt;
      bit          crosses;
      m = MODS[i];
      if (c) begin
         m_out[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
      end else if (l) begin
         m_out[i]  = (32'(dv) >= m) ? m - 1 : 32'(dv);
         m_wrap[i] = 0;
      end else if (!e) begin
         m_wrap[i] = 0;
      end else begin
         nxt       = u ? m_out[i] + 1 : m_out[i] + m - 1;
         crosses   = u ? (nxt == m) : (m_out[i] == 0);
         m_wrap[i] = 0;
         if (!crosses) begin
            m_out[i] = nxt % m;
         end else begin
            m_ovf[i] = 1;
            if (!SATS[i]) begin
               m_out[i]  = nxt % m;
               m_wrap[i] = 1;
            end
         end
      end
   endfunction

   task automatic apply(input bit e, input bit u, input bit c, input bit l,
                        input logic [W-1:0] dv);
      exp_t x;
      bit   ein [NI];
      en = e; up = u; clr = c; load = l; d = dv;
      for (int i = 0; i < NI; i++) begin
         ein[i]    = (i == 3) ? x.tc[2] : e;
         x.out[i]  = W'(m_out[i]);
         x.wrap[i] = m_wrap[i];
         x.ovf[i]  = m_ovf[i];
         x.tc[i]   = ein[i] && (m_out[i] == (u ? MODS[i] - 1 : 0));
      end
      sb.push_back(x);
      pushed++;
      for (int i = 0; i < NI; i++) advance(i, ein[i], u, c, l, dv);
   endtask

   task automatic step(input bit e, input bit u, input bit c, input bit l,
                       input logic [W-1:0] dv);
      @(posedge clk);
      #1;
      apply(e, u, c, l, dv);
   endtask

   task automatic check_zero(input string name);
      for (int i = 0; i < NI; i++)
         chk(name, {30'(a_out[i]), a_wrap[i], a_ovf[i]}, 32'd0);
   endtask

   // Assert reset between edges, hold it across one edge, release with counting enabled.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero("rst_async");
      for (int i = 0; i < NI; i++) begin
         m_out[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
      end
      @(posedge clk);
      #1;
      check_zero("rst_hold");
      #1;
      rst = 1'b0;
      apply(1'b1, 1'b1, 1'b0, 1'b0, '0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            popped++;
            for (int i = 0; i < NI; i++) begin
               checks++;
               if ({a_out[i], a_wrap[i], a_ovf[i], a_tc[i]} !==
                   {x.out[i], x.wrap[i], x.ovf[i], x.tc[i]}) begin
                  errors++;
                  $display("FAIL sb inst%0d t=%0t: out=%0d wrap=%0b ovf=%0b tc=%0b, required out=%0d wrap=%0b ovf=%0b tc=%0b",
                           i, $time, a_out[i], a_wrap[i], a_ovf[i], a_tc[i],
                           x.out[i], x.wrap[i], x.ovf[i], x.tc[i]);
               end
            end
         end
      end
   end

   initial begin : driver
      for (int i = 0; i < NI; i++) begin
         m_out[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
      end
      #1;
      check_zero("rst_initial");

      // Count up through the mod-10 wrap, then park at 6 with overflow set.
      do_reset();
      for (int k = 0; k < 15; k++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("pre_rst_out", 32'(a_out[0]), 32'd6);
      chk("pre_rst_ovf", 32'(a_ovf[0]), 32'd1);

      // Mid-count async reset, then 40 counts through the cascade.
      do_reset();
      for (int k = 0; k < 39; k++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("cascade_40", {24'd0, a_out[3], a_out[2]}, 32'h28);
      chk("m10_after_40", 32'(a_out[0]), 32'd0);

      // Count down from zero.
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("tc_down_at0", 32'(a_tc[0]), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("down_3", 32'(a_out[0]), 32'd7);

      // Saturation: clear, load 8, push up four times.
      step(1'b0, 1'b1, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("sat_out", 32'(a_out[1]), 32'd9);
      chk("sat_ovf", 32'(a_ovf[1]), 32'd1);

      // Clear beats load; oversize load clamps; enable low holds.
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("clr_prio_out", 32'(a_out[0]), 32'd0);
      chk("clr_prio_ovf", 32'(a_ovf[0]), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("clamp_hold", 32'(a_out[0]), 32'd9);

      // Random traffic.
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, W'($urandom));
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);

      @(negedge clk);
      @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("sb_balance", 32'(popped), 32'(pushed));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/counter_mod_updown.md
Name: counter_mod_updown

Overview:
- Parametrised successor to the team's 4-bit free-running counter, which has only CLK, RESET, OUT and TC.
- Adds configurable width and modulus, up/down direction, enable, synchronous clear and load, and a wrap-or-saturate mode.
- Adds a registered wrap pulse and a sticky overflow flag.
- Used as a standalone DUT in interactive benches and cascadable via TC into EN of the next stage.

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2..2^WIDTH; elaboration error outside it.
- SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- EN  input  1  count enable.
- UP  input  1  direction: 1 = up, 0 = down.
- CLR  input  1  synchronous clear.
- LOAD  input  1  synchronous load.
- D  input  WIDTH  load value.
- OUT  output  WIDTH  current count (registered).
- TC  output  1  terminal count, combinational.
- WRAP  output  1  registered one-cycle pulse on wrap.
- OVF  output  1  sticky overflow flag.

Behaviour:
- Clocking and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: while RESET=1, OUT=0, WRAP=0, OVF=0 immediately, with no clock needed. First count occurs on the first rising edge after RESET deasserts.
- Reset mid-operation: asserting RESET during counting clears the count and both flags at once. No partial update survives.
- Terminal value: TERM = MODULUS-1 when UP=1, 0 when UP=0.
- TC = EN & (OUT == TERM). Purely combinational.
  - Cascade: feed TC to the EN of the next stage, with UP shared.
- Per-edge priority, highest first:
  1. CLR=1: OUT<=0, WRAP<=0, OVF<=0.
  2. LOAD=1: OUT<=D, or OUT<=MODULUS-1 if D>=MODULUS (clamp). WRAP<=0. OVF unchanged. EN is ignored.
  3. EN=1, OUT!=TERM: OUT<=OUT+1 (UP=1) or OUT-1 (UP=0). WRAP<=0.
  4. EN=1, OUT==TERM, SATURATE=0: OUT<=0 (up) or MODULUS-1 (down). WRAP<=1. OVF<=1.
  5. EN=1, OUT==TERM, SATURATE=1: OUT holds. WRAP<=0. OVF<=1.
  6. EN=0: OUT holds. WRAP<=0.
- Arithmetic: modulo MODULUS, not 2^WIDTH. OUT never leaves 0..MODULUS-1.
  - Next-value computation is done at WIDTH+1 bits to avoid truncation when MODULUS=2^WIDTH.
- Latency: OUT changes one clock after the enabling condition. WRAP is high exactly one cycle, aligned with the wrapped OUT value.
- UP changing while OUT==TERM: TC follows the new direction combinationally in the same cycle.
  - Example: OUT=0 with UP switching 1->0 gives TC=EN at once.
- OVF is cleared only by CLR or RESET. LOAD and direction changes leave it set.
- No internal state beyond OUT, WRAP and OVF. No FSM beyond the priority decode above.

Test Plan:
- Reset and wrap count-up (WIDTH=4, MODULUS=10, SATURATE=0): pulse RESET, then EN=1, UP=1 for 12 clocks.
  - Required: OUT is 0 during reset, then 1..9,0,1,2.
  - TC=1 only while OUT=9.
  - WRAP=1 for exactly the cycle OUT=0 after 9.
  - OVF=1 from then on.
- Count-down wrap (MODULUS=10): from OUT=0 with EN=1, UP=0, clock 3 times.
  - Required: OUT=9,8,7; WRAP high on the first cycle only.
  - TC=1 at OUT=0 before the first edge.
- Saturate (SATURATE=1, MODULUS=10): load 8, then UP=1, EN=1 for 4 clocks.
  - Required: OUT=9,9,9,9; WRAP stays 0; OVF=1 after the second edge; TC=1 throughout at 9.
- Priority and clamp:
  - Assert CLR and LOAD together with D=5, EN=1: OUT=0 and OVF cleared.
  - Then LOAD with D=15 at MODULUS=10: OUT=9 and OVF unchanged.
  - Then EN=0 for 3 clocks: OUT holds at 9.
- Async reset mid-count: assert RESET between edges while OUT=6 and OVF=1.
  - Required: OUT=0, OVF=0 and WRAP=0 before the next edge.
  - Counting resumes at 1 on the first edge after release.
- Full-range boundary (WIDTH=4, MODULUS=16): count up from 15.
  - Required: OUT=0 with WRAP=1 and no truncation glitch.
  - Two cascaded instances (TC0 driven into EN1) run for 40 clocks: {OUT1,OUT0} = 0x28.
